// File: rtl/memory_bus_responder.sv
// rtl/memory_bus_responder.sv - wait-state memory responder for the MAR/MDR memory bus
//
// Services single-word read/write requests from the memory bus controller out of an
// internal word-addressed RAM. Each access is latched in IDLE, held for WAIT_STATES
// cycles and completed with a one-cycle mem_ready pulse.
//
// Optional feature macro: MEM_ERR_EN (adds mem_err, range checking and read/write
// conflict reporting; without it high addresses alias and conflicts are ignored).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   mem_addr   in   word address from the controller's MAR
//   mem_wdata  in   write data from the controller's MDR
//   mem_read   in   read request
//   mem_write  in   write request
//   mem_rdata  out  registered read data, held between reads
//   mem_ready  out  one-cycle access-complete pulse
//   mem_busy   out  high while an access is in progress
//   mem_err    out  error flag qualified by mem_ready (MEM_ERR_EN only)

module memory_bus_responder #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_busy
`ifdef MEM_ERR_EN
    ,
    output logic                  mem_err
`endif
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WS_INIT = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    acc_err_q, acc_err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    err_out_q, err_out_d;

    logic                    start;
    logic                    new_err;
    logic                    exec;
    logic                    ram_we;

    // Contents are deliberately not reset.
    logic [DATA_WIDTH-1:0]   ram [DEPTH];

`ifdef MEM_ERR_EN
    // Both requests high is a conflict access; full-width address is range checked.
    assign start   = mem_read | mem_write;
    assign new_err = (mem_read & mem_write) | ((mem_addr >> DEPTH_LOG2) != '0);
    assign mem_err = err_out_q;
`else
    // Conflicting requests are ignored; high address bits alias onto the RAM.
    logic unused_sig;
    assign start      = mem_read ^ mem_write;
    assign new_err    = 1'b0;
    assign unused_sig = ^{mem_addr, err_out_q};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        acc_err_d = acc_err_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_out_d = 1'b0;
        exec      = 1'b0;
        ram_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wr_d      = mem_write;
                    idx_d     = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d   = mem_wdata;
                    acc_err_d = new_err;
                    cnt_d     = WS_INIT;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        exec    = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    exec    = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The access executes on the edge entering RESP. The *_d access fields hold
        // the latched values here (or the just-sampled ones when WAIT_STATES is 0).
        if (exec) begin
            ready_d = 1'b1;
            if (acc_err_d) begin
                rdata_d   = '0;
                err_out_d = 1'b1;
            end else if (wr_d) begin
                ram_we = 1'b1;
            end else begin
                rdata_d = ram[idx_d];
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            acc_err_q <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            acc_err_q <= acc_err_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_out_q <= err_out_d;
        end
    end

    // Gated by rst so an access aborted by reset can never commit its write.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[idx_d] <= wdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_busy  = busy_q;

endmodule

// File: tb/tb_memory_bus_responder.sv
// tb/tb_memory_bus_responder.sv - randomized self-checking bench for memory_bus_responder

module tb_memory_bus_responder;

    logic        clk;
    logic        rst;
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [15:0] rdata [2];
    logic        rdy   [2];
    logic        busy  [2];
`ifdef MEM_ERR_EN
    logic        err   [2];
`endif

    int          ws_of [2];
    logic [15:0] model_mem [2][256];
    logic [15:0] exp_rdata [2];
    int          n_checks;
    int          n_fail;

    memory_bus_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (addr[0]),
        .mem_wdata (wdata[0]),
        .mem_read  (rd[0]),
        .mem_write (wr[0]),
        .mem_rdata (rdata[0]),
        .mem_ready (rdy[0]),
        .mem_busy  (busy[0])
`ifdef MEM_ERR_EN
        ,
        .mem_err   (err[0])
`endif
    );

    memory_bus_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (addr[1]),
        .mem_wdata (wdata[1]),
        .mem_read  (rd[1]),
        .mem_write (wr[1]),
        .mem_rdata (rdata[1]),
        .mem_ready (rdy[1]),
        .mem_busy  (busy[1])
`ifdef MEM_ERR_EN
        ,
        .mem_err   (err[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus transaction following the initiator rule, checked against the model.
    task automatic do_access(input int u, input bit w, input bit r, input logic [15:0] a,
                             input logic [15:0] d, input bit sc_en,
                             input logic [15:0] sc_a, input logic [15:0] sc_d);
        bit   is_err;
        int   n;
        int   busy_cycles;
        logic [7:0] idx;
        idx    = a[7:0];
`ifdef MEM_ERR_EN
        is_err = (w && r) || (a >= 16'd256);
`else
        is_err = 1'b0;
`endif
        @(negedge clk);
        addr[u] = a; wdata[u] = d; rd[u] = r; wr[u] = w;
`ifndef MEM_ERR_EN
        if (w && r) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                check_eq("conflict_ignored_busy", busy[u], 1'b0);
                check_eq("conflict_ignored_ready", rdy[u], 1'b0);
            end
            rd[u] = 1'b0; wr[u] = 1'b0;
            return;
        end
`endif
        n = 0;
        busy_cycles = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy[u]) busy_cycles++;
            if (rdy[u]) break;
            if (sc_en && n == 1) begin
                addr[u] = sc_a; wdata[u] = sc_d;
            end
        end
        check_eq("ready_latency", n, ws_of[u] + 1);
        check_eq("busy_cycles", busy_cycles, ws_of[u] + 1);
        if (is_err) begin
            exp_rdata[u] = 16'h0000;
        end else if (w) begin
            model_mem[u][idx] = d;
        end else begin
            exp_rdata[u] = model_mem[u][idx];
        end
        check_eq("rdata_at_ready", rdata[u], exp_rdata[u]);
`ifdef MEM_ERR_EN
        check_eq("err_at_ready", err[u], is_err);
`endif
        rd[u] = 1'b0; wr[u] = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_pulse_end", rdy[u], 1'b0);
        check_eq("busy_end", busy[u], 1'b0);
        check_eq("rdata_held", rdata[u], exp_rdata[u]);
`ifdef MEM_ERR_EN
        check_eq("err_low_without_ready", err[u], 1'b0);
`endif
    endtask

    task automatic plain(input int u, input bit w, input logic [15:0] a, input logic [15:0] d);
        do_access(u, w, !w, a, d, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ws_of[0] = 2;
        ws_of[1] = 0;
        for (int u = 0; u < 2; u++) begin
            addr[u] = '0; wdata[u] = '0; rd[u] = 1'b0; wr[u] = 1'b0;
            exp_rdata[u] = 16'h0000;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check_eq("reset_rdata", rdata[u], 16'h0000);
            check_eq("reset_ready", rdy[u], 1'b0);
            check_eq("reset_busy", busy[u], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Fill both RAMs so every later read has a known expected value.
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 256; i++)
                plain(u, 1'b1, 16'(i), 16'($urandom));

        // Write/read with two wait states, then with none.
        plain(0, 1'b1, 16'h0012, 16'hBEEF);
        plain(0, 1'b0, 16'h0012, 16'h0000);
        check_eq("ws2_readback", rdata[0], 16'hBEEF);
        plain(1, 1'b1, 16'h0005, 16'h1234);
        plain(1, 1'b0, 16'h0005, 16'h0000);
        check_eq("ws0_readback", rdata[1], 16'h1234);

        // Bus changes after the sampling edge must not affect the access.
        do_access(0, 1'b1, 1'b0, 16'h0010, 16'h5A5A, 1'b1, 16'h0013, 16'h0000);
        plain(0, 1'b0, 16'h0010, 16'h0000);
        check_eq("stable_0010", rdata[0], 16'h5A5A);
        plain(0, 1'b0, 16'h0013, 16'h0000);

        // Asynchronous reset clears outputs without a clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_rdata", rdata[0], 16'h0000);
        check_eq("async_rst_ready", rdy[0], 1'b0);
        check_eq("async_rst_busy", busy[0], 1'b0);
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;
        @(negedge clk);
        rst = 1'b0;

        // Reset during WAIT aborts the write.
        plain(0, 1'b1, 16'h0020, 16'h0001);
        @(negedge clk);
        addr[0] = 16'h0020; wdata[0] = 16'hFFFF; wr[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_busy_in_wait", busy[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy_cleared", busy[0], 1'b0);
        wr[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_eq("abort_no_ready", rdy[0], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;
        plain(0, 1'b0, 16'h0020, 16'h0000);
        check_eq("abort_readback", rdata[0], 16'h0001);

        // Out-of-range write and read/write conflict, then read of word 0.
        plain(0, 1'b1, 16'h0100, 16'h7777);
        do_access(0, 1'b1, 1'b1, 16'h0001, 16'h4242, 1'b0, 16'h0, 16'h0);
        plain(0, 1'b0, 16'h0000, 16'h0000);
`ifndef MEM_ERR_EN
        check_eq("alias_0100_to_0000", rdata[0], 16'h7777);
`endif

        // Randomized traffic on both units.
        for (int t = 0; t < 200; t++) begin
            int   u;
            int   op;
            u  = int'($urandom_range(1, 0));
            op = int'($urandom_range(9, 0));
            do_access(u, op >= 5 || op == 0, op < 5, 16'($urandom_range(16'h01FF, 0)),
                      16'($urandom), ($urandom_range(1, 0) == 1),
                      16'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
